// File: rtl/riscv_program_loader_param_pkg.sv
// Shared definitions for the parametrised RISC-V program loader.
// Holds the FSM state encoding, the default frame start byte, the width of
// the length field, and a helper that names the states in which the
// inter-byte timeout is running.
package riscv_program_loader_param_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LEN_LO,
    LDR_LEN_HI,
    LDR_DATA,
    LDR_WRITE,
    LDR_CSUM,
    LDR_DONE
  } ldr_state_t;

  localparam logic [7:0]  DEFAULT_MAGIC = 8'hA5;
  localparam int unsigned LEN_WIDTH     = 16;

  // States in which the loader is waiting for the host's next byte.
  function automatic logic waits_for_byte(input ldr_state_t s);
    return s inside {LDR_LEN_LO, LDR_LEN_HI, LDR_DATA, LDR_CSUM};
  endfunction

endpackage

// File: rtl/riscv_loader_word_packer.sv
// Packs a little-endian byte stream into DATA_WIDTH-bit words.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clear       restart packing at byte 0 with an all-zero word
//   shift_en    byte_in is consumed this cycle
//   byte_in     incoming byte; the first byte of a word lands in bits [7:0]
//   word        word being assembled (complete once word_full has fired)
//   word_full   high in the cycle whose shifted byte completes the word
module riscv_loader_word_packer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int unsigned BPW = DATA_WIDTH / 8;
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [CW-1:0] byte_cnt;

  assign word_full = shift_en && (byte_cnt == LAST);

  // NOTE: reset is sampled synchronously, and all state updates use <= so
  // every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < BPW; i++) begin
        if (byte_cnt == CW'(i)) word[i*8 +: 8] <= byte_in;
      end
      byte_cnt <= word_full ? '0 : byte_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/riscv_program_loader_param.sv
// Boot loader between the UART receive stream and the memory write port.
// Frame: MAGIC, len_lo, len_hi, len*BPW payload bytes, checksum byte, where
// the checksum is the mod-256 sum of the length and payload bytes.
// Ports:
//   rx_valid/rx_data/rx_ready   UART byte stream (accepted on valid&&ready)
//   load_req                    pulse: abandon the current image and reload
//   mem_we/mem_addr/mem_wdata   memory write request, held until mem_ready
//   mem_ready                   write completes when mem_we && mem_ready
//   cpu_rst_n                   released only once a verified image is loaded
//   loading_complete            verified image resident
//   load_error                  last frame failed; cleared by the next MAGIC
//   words_loaded                payload words written in the current frame
module riscv_program_loader_param
  import riscv_program_loader_param_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter logic [7:0]  MAGIC          = DEFAULT_MAGIC,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  load_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  output logic                  cpu_rst_n,
  output logic                  loading_complete,
  output logic                  load_error,
  output logic [LEN_WIDTH-1:0]  words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [LEN_WIDTH-1:0]  MAX_LEN = LEN_WIDTH'(MAX_WORDS);
  // Last idle count before expiry; unused when the timeout is disabled.
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  ldr_state_t           state;
  logic [7:0]           len_lo;
  logic [LEN_WIDTH-1:0] frame_len;
  logic [7:0]           checksum;
  logic [31:0]          idle_timer;

  logic                 accept;
  logic                 frame_start;
  logic                 frame_error;
  logic                 pk_word_full;
  logic [LEN_WIDTH-1:0] len_rx;

  assign accept      = rx_valid && rx_ready;
  assign len_rx      = {rx_data, len_lo};
  assign frame_start = (state == LDR_IDLE) && accept && (rx_data == MAGIC);

  // Packed payload word drives mem_wdata directly; it cannot change during
  // WRITE because rx_ready is low there.
  riscv_loader_word_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (load_req || frame_start),
    .shift_en  ((state == LDR_DATA) && accept && !load_req),
    .byte_in   (rx_data),
    .word      (mem_wdata),
    .word_full (pk_word_full)
  );

  // A byte arriving in the expiry cycle rescues the frame.
  always_comb begin
    // NOTE: default first so no path leaves frame_error unassigned (no latch).
    frame_error = 1'b0;
    case (state)
      LDR_LEN_HI: if (accept && (len_rx > MAX_LEN))    frame_error = 1'b1;
      LDR_CSUM:   if (accept && (rx_data != checksum)) frame_error = 1'b1;
      default:    ;
    endcase
    if ((TIMEOUT_CYCLES != 0) && waits_for_byte(state) && !accept &&
        (idle_timer == TIMEOUT_LAST))
      frame_error = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= LDR_IDLE;
      rx_ready         <= 1'b1;
      mem_we           <= 1'b0;
      mem_addr         <= BASE;
      cpu_rst_n        <= 1'b0;
      loading_complete <= 1'b0;
      load_error       <= 1'b0;
      words_loaded     <= '0;
      checksum         <= '0;
      idle_timer       <= '0;
      len_lo           <= '0;
      frame_len        <= '0;
    end else if (load_req) begin
      // Reload wins over everything, including a byte offered this cycle.
      state            <= LDR_IDLE;
      rx_ready         <= 1'b1;
      mem_we           <= 1'b0;
      cpu_rst_n        <= 1'b0;
      loading_complete <= 1'b0;
      idle_timer       <= '0;
    end else if (frame_error) begin
      state            <= LDR_IDLE;
      rx_ready         <= 1'b1;
      mem_we           <= 1'b0;
      cpu_rst_n        <= 1'b0;
      loading_complete <= 1'b0;
      load_error       <= 1'b1;
      idle_timer       <= '0;
    end else begin
      idle_timer <= (waits_for_byte(state) && !accept) ? idle_timer + 32'd1 : '0;
      case (state)
        LDR_IDLE: begin
          if (frame_start) begin
            load_error   <= 1'b0;
            checksum     <= '0;
            words_loaded <= '0;
            mem_addr     <= BASE;
            state        <= LDR_LEN_LO;
          end
        end
        LDR_LEN_LO: begin
          if (accept) begin
            len_lo   <= rx_data;
            checksum <= checksum + rx_data;
            state    <= LDR_LEN_HI;
          end
        end
        LDR_LEN_HI: begin
          if (accept) begin
            frame_len <= len_rx;
            checksum  <= checksum + rx_data;
            state     <= (len_rx == '0) ? LDR_CSUM : LDR_DATA;
          end
        end
        LDR_DATA: begin
          if (accept) begin
            checksum <= checksum + rx_data;
            if (pk_word_full) begin
              state    <= LDR_WRITE;
              mem_we   <= 1'b1;
              rx_ready <= 1'b0;
            end
          end
        end
        LDR_WRITE: begin
          if (mem_ready) begin
            mem_we       <= 1'b0;
            rx_ready     <= 1'b1;
            mem_addr     <= mem_addr + ADDR_WIDTH'(1);
            words_loaded <= words_loaded + 16'd1;
            state        <= (words_loaded + 16'd1 == frame_len) ? LDR_CSUM : LDR_DATA;
          end
        end
        LDR_CSUM: begin
          // A mismatch is handled by the frame_error branch.
          if (accept) begin
            state            <= LDR_DONE;
            loading_complete <= 1'b1;
            cpu_rst_n        <= 1'b1;
          end
        end
        default: ;  // LDR_DONE: hold, drop every byte until load_req
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_program_loader_param.sv
// Self-checking bench for riscv_program_loader_param. Two instances: dut_a
// (32-bit words, base 0, 20-cycle timeout) and dut_b (16-bit words, base
// 0xFFFF, timeout disabled). `sel` routes the shared stimulus to one of them.
// Expected memory writes come from a frame-level model (payload bytes ->
// little-endian words at consecutive wrapping addresses).
module tb_riscv_program_loader_param;

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic load_req = 1'b0;
  logic mem_ready = 1'b1;
  int ready_mode = 0;
  int stall_left = 0;

  logic rx_ready_a, mem_we_a, cpu_rst_n_a, complete_a, error_a;
  logic rx_ready_b, mem_we_b, cpu_rst_n_b, complete_b, error_b;
  logic [15:0] addr_a, addr_b, words_a, words_b;
  logic [31:0] wdata_a;
  logic [15:0] wdata_b;

  logic rx_ready_s, mem_we_s, cpu_rst_n_s, complete_s, error_s;
  logic [15:0] mem_addr_s, words_s;
  logic [63:0] wdata_s;

  int n_checks = 0;
  int n_pass = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int hold_q[$];

  always #5 clk = ~clk;

  riscv_program_loader_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .BASE_ADDR(0), .MAX_WORDS(4096),
    .MAGIC(MAGIC), .TIMEOUT_CYCLES(20)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid && !sel), .rx_data(rx_data), .rx_ready(rx_ready_a),
    .load_req(load_req && !sel),
    .mem_we(mem_we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_ready(mem_ready),
    .cpu_rst_n(cpu_rst_n_a), .loading_complete(complete_a), .load_error(error_a),
    .words_loaded(words_a)
  );

  riscv_program_loader_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(32'hFFFF), .MAX_WORDS(4096),
    .MAGIC(MAGIC), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid && sel), .rx_data(rx_data), .rx_ready(rx_ready_b),
    .load_req(load_req && sel),
    .mem_we(mem_we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_ready(mem_ready),
    .cpu_rst_n(cpu_rst_n_b), .loading_complete(complete_b), .load_error(error_b),
    .words_loaded(words_b)
  );

  assign rx_ready_s  = sel ? rx_ready_b  : rx_ready_a;
  assign mem_we_s    = sel ? mem_we_b    : mem_we_a;
  assign cpu_rst_n_s = sel ? cpu_rst_n_b : cpu_rst_n_a;
  assign complete_s  = sel ? complete_b  : complete_a;
  assign error_s     = sel ? error_b     : error_a;
  assign mem_addr_s  = sel ? addr_b      : addr_a;
  assign words_s     = sel ? words_b     : words_a;
  assign wdata_s     = sel ? 64'(wdata_b) : 64'(wdata_a);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // mem_ready driver: 0 = always ready, 1 = random, 2 = stall stall_left
  // write cycles then ready, other = never ready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom_range(0, 2) != 0);
      2: if (mem_we_s && stall_left > 0) begin
           mem_ready = 1'b0;
           stall_left--;
         end else mem_ready = 1'b1;
      default: mem_ready = 1'b0;
    endcase
  end

  // Write monitor: logs completed writes, checks hold stability while stalled.
  int hold_len = 0;
  logic pend = 1'b0;
  logic [15:0] p_addr = '0;
  logic [63:0] p_data = '0;
  always @(negedge clk) begin
    if (rst_n && mem_we_s) begin
      wr_t w;
      check("wr_rx_ready_low", 64'(rx_ready_s), 64'd0);
      if (pend) begin
        check("hold_addr", 64'(mem_addr_s), 64'(p_addr));
        check("hold_data", wdata_s, p_data);
      end
      hold_len++;
      if (mem_ready) begin
        w.addr = mem_addr_s;
        w.data = wdata_s;
        got_q.push_back(w);
        hold_q.push_back(hold_len);
        hold_len = 0;
        pend = 1'b0;
      end else begin
        pend = 1'b1;
        p_addr = mem_addr_s;
        p_data = wdata_s;
      end
    end else begin
      pend = 1'b0;
      hold_len = 0;
    end
  end

  function automatic logic [7:0] frame_sum(input int len, input logic [7:0] pl[$]);
    int s = (len & 255) + ((len >> 8) & 255);
    foreach (pl[i]) s += int'(pl[i]);
    return 8'(s);
  endfunction

  task automatic model_writes(input logic [7:0] pl[$], input int bpw, input logic [15:0] base);
    exp_q.delete();
    for (int w = 0; w < pl.size() / bpw; w++) begin
      wr_t e;
      e.addr = base + 16'(w);
      e.data = '0;
      for (int k = 0; k < bpw; k++) e.data[8*k +: 8] = pl[w*bpw + k];
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_data"}, got_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
    int n = 0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_wait", 64'(rx_ready_s), 64'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_body(input int len, input logic [7:0] pl[$], input bit bad,
                           input int unsigned gap);
    logic [7:0] cs;
    cs = frame_sum(len, pl) ^ (bad ? 8'h01 : 8'h00);
    send_byte(8'(len), gap);
    send_byte(8'(len >> 8), gap);
    foreach (pl[i]) send_byte(pl[i], gap);
    send_byte(cs, gap);
  endtask

  task automatic send_frame(input int len, input logic [7:0] pl[$], input bit bad,
                            input int unsigned gap);
    send_byte(MAGIC, gap);
    send_body(len, pl, bad, gap);
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] empty[$];
    int len;
    bit bad;

    // Reset state of both instances
    repeat (3) @(negedge clk);
    check("rst_rx_ready_a", 64'(rx_ready_a), 64'd1);
    check("rst_mem_we_a", 64'(mem_we_a), 64'd0);
    check("rst_addr_a", 64'(addr_a), 64'h0);
    check("rst_wdata_a", 64'(wdata_a), 64'h0);
    check("rst_cpu_a", 64'(cpu_rst_n_a), 64'd0);
    check("rst_complete_a", 64'(complete_a), 64'd0);
    check("rst_error_a", 64'(error_a), 64'd0);
    check("rst_words_a", 64'(words_a), 64'd0);
    check("rst_addr_b", 64'(addr_b), 64'hFFFF);
    rst_n = 1'b1;

    // Reference frame with the first write stalled for 5 cycles
    for (int i = 0; i < 8; i++) pl.push_back(8'((i + 1) * 17));
    ready_mode = 2;
    stall_left = 5;
    send_frame(2, pl, 1'b0, 0);
    check("a_complete", 64'(complete_s), 64'd1);
    check("a_cpu_rst_n", 64'(cpu_rst_n_s), 64'd1);
    check("a_words", 64'(words_s), 64'd2);
    model_writes(pl, 4, 16'h0000);
    compare_writes("a_wr");
    check("a_hold_first", 64'(hold_q[0]), 64'd6);
    check("a_hold_second", 64'(hold_q[1]), 64'd1);
    ready_mode = 0;

    // DONE drops everything including MAGIC
    send_byte(MAGIC, 0);
    for (int i = 0; i < 6; i++) send_byte(8'h11, 0);
    repeat (3) @(negedge clk);
    check("done_hold_complete", 64'(complete_s), 64'd1);
    check("done_no_writes", 64'(got_q.size()), 64'd2);

    // Reload request
    pulse_load_req();
    check("lreq_cpu", 64'(cpu_rst_n_s), 64'd0);
    check("lreq_complete", 64'(complete_s), 64'd0);
    check("lreq_error", 64'(error_s), 64'd0);

    // Bad checksum, then a good frame
    got_q.delete();
    send_frame(2, pl, 1'b1, 0);
    check("badcs_error", 64'(error_s), 64'd1);
    check("badcs_cpu", 64'(cpu_rst_n_s), 64'd0);
    check("badcs_complete", 64'(complete_s), 64'd0);
    compare_writes("badcs_wr");
    send_byte(MAGIC, 0);
    check("magic_clears_error", 64'(error_s), 64'd0);
    send_body(2, pl, 1'b0, 0);
    check("good_after_bad", 64'(complete_s), 64'd1);

    // Inter-byte timeout after byte 5
    pulse_load_req();
    got_q.delete();
    send_byte(MAGIC, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (19) @(posedge clk);
    #1 check("tmo_not_yet", 64'(error_s), 64'd0);
    @(posedge clk);
    #1 check("tmo_error", 64'(error_s), 64'd1);
    check("tmo_cpu", 64'(cpu_rst_n_s), 64'd0);
    for (int i = 3; i < 9; i++) send_byte(8'(i * 17), 0);
    repeat (3) @(negedge clk);
    check("tmo_dropped", 64'(got_q.size()), 64'd0);
    check("tmo_error_sticky", 64'(error_s), 64'd1);

    // Oversize length, then exactly MAX_WORDS
    send_byte(MAGIC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    check("len1001_error", 64'(error_s), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(8'h5A, 0);
    repeat (3) @(negedge clk);
    check("len1001_no_we", 64'(got_q.size()), 64'd0);
    send_byte(MAGIC, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    check("len1000_ok", 64'(error_s), 64'd0);
    pulse_load_req();

    // Zero-length image
    send_frame(0, empty, 1'b0, 0);
    check("len0_complete", 64'(complete_s), 64'd1);
    check("len0_words", 64'(words_s), 64'd0);
    check("len0_no_writes", 64'(got_q.size()), 64'd0);

    // Randomised frames against the model
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      pulse_load_req();
      got_q.delete();
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 8'hA4)), 1);
      len = int'($urandom_range(1, 5));
      bad = ($urandom_range(0, 3) == 0);
      pl.delete();
      for (int i = 0; i < len * 4; i++) pl.push_back(8'($urandom_range(0, 255)));
      send_frame(len, pl, bad, 3);
      model_writes(pl, 4, 16'h0000);
      compare_writes("rnd_wr");
      check("rnd_complete", 64'(complete_s), 64'(!bad));
      check("rnd_error", 64'(error_s), 64'(bad));
      check("rnd_cpu", 64'(cpu_rst_n_s), 64'(!bad));
      check("rnd_words", 64'(words_s), 64'(len));
    end
    ready_mode = 0;

    // 16-bit instance: address wrap from 0xFFFF
    repeat (2) @(negedge clk);
    sel = 1'b1;
    got_q.delete();
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame(2, pl, 1'b0, 0);
    model_writes(pl, 2, 16'hFFFF);
    compare_writes("b_wrap");
    check("b_complete", 64'(complete_s), 64'd1);

    // 16-bit instance: reload during the second write
    pulse_load_req();
    got_q.delete();
    send_byte(MAGIC, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(pl[0], 0);
    send_byte(pl[1], 0);
    repeat (2) @(posedge clk);
    #1 ready_mode = 3;
    send_byte(pl[2], 0);
    send_byte(pl[3], 0);
    @(negedge clk);
    check("abort_we_before", 64'(mem_we_s), 64'd1);
    check("abort_addr", 64'(mem_addr_s), 64'h0000);
    pulse_load_req();
    check("abort_we_dropped", 64'(mem_we_s), 64'd0);
    check("abort_cpu", 64'(cpu_rst_n_s), 64'd0);
    check("abort_complete", 64'(complete_s), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_writes", 64'(got_q.size()), 64'd1);
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
